// File: rtl/iobank0_ctrl.sv
// iobank0_ctrl: register-mapped controller for a tristate IO bank with alt-function mux,
// input synchroniser and rising-edge interrupts. Define IOBANK0_CTRL_DEBOUNCE_EN for debounce.
module iobank0_ctrl #(
    parameter int NPADS      = 20,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    input  logic [NPADS-1:0] alt_o,
    input  logic [NPADS-1:0] alt_oe,
    output logic [NPADS-1:0] alt_i,
    output logic [NPADS-1:0] pad_o,
    output logic [NPADS-1:0] pad_oe,
    input  logic [NPADS-1:0] pad_i,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_OE      = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_ALTSEL  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd4;
    localparam logic [2:0] ADDR_IRQ_ST  = 3'd5;
    localparam logic [2:0] ADDR_OUT_SET = 3'd6;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd7;

    logic [NPADS-1:0] out_q, out_d;
    logic [NPADS-1:0] oe_q, oe_d;
    logic [NPADS-1:0] altsel_q, altsel_d;
    logic [NPADS-1:0] irq_en_q, irq_en_d;
    logic [NPADS-1:0] irq_stat_q, irq_stat_d;
    logic [NPADS-1:0] pad_o_q, pad_o_d;
    logic [NPADS-1:0] pad_oe_q, pad_oe_d;
    logic [NPADS-1:0] sync1_q, sync2_q;
    logic [NPADS-1:0] in_prev_q;
    logic [NPADS-1:0] in_val;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;

    logic             acc;
    logic             wr;
    logic [NPADS-1:0] wdata;
    logic [NPADS-1:0] w1c;
    logic [NPADS-1:0] rd_pads;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    // Handshake: a request transfers on a cycle with req_valid & req_ready; the response
    // transfers on rsp_valid & rsp_ready. Only one transaction is in flight, so req_ready
    // is low for as long as a response is waiting, and the response stays stable until taken.
    assign req_ready    = ~rsp_valid_q;
    assign acc          = req_valid & req_ready;
    assign wr           = acc & req_we;
    assign wdata        = req_wdata[NPADS-1:0];
    assign unused_wdata = ^req_wdata;

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        altsel_d = altsel_q;
        irq_en_d = irq_en_q;
        w1c      = '0;
        if (wr) begin
            case (req_addr)
                ADDR_OUT:     out_d    = wdata;
                ADDR_OE:      oe_d     = wdata;
                ADDR_ALTSEL:  altsel_d = wdata;
                ADDR_IRQ_EN:  irq_en_d = wdata;
                ADDR_IRQ_ST:  w1c      = wdata;
                ADDR_OUT_SET: out_d    = out_q | wdata;
                ADDR_OUT_CLR: out_d    = out_q & ~wdata;
                default:      ;
            endcase
        end
        // A hardware set is OR-ed in after the clear so it wins over a same-cycle W1C.
        irq_stat_d = (irq_stat_q & ~w1c) | (in_val & ~in_prev_q & irq_en_q);
    end

    always_comb begin
        rd_pads = '0;
        case (req_addr)
            ADDR_OUT:    rd_pads = out_q;
            ADDR_OE:     rd_pads = oe_q;
            ADDR_IN:     rd_pads = in_val;
            ADDR_ALTSEL: rd_pads = altsel_q;
            ADDR_IRQ_EN: rd_pads = irq_en_q;
            ADDR_IRQ_ST: rd_pads = irq_stat_q;
            default:     rd_pads = '0;
        endcase
        rd_word              = '0;
        rd_word[NPADS-1:0]   = rd_pads;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we ? 32'd0 : rd_word;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'd0;
        end
    end

    assign pad_o_d  = (altsel_q & alt_o)  | (~altsel_q & out_q);
    assign pad_oe_d = (altsel_q & alt_oe) | (~altsel_q & oe_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            oe_q        <= '0;
            altsel_q    <= '0;
            irq_en_q    <= '0;
            irq_stat_q  <= '0;
            pad_o_q     <= '0;
            pad_oe_q    <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            in_prev_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            altsel_q    <= altsel_d;
            irq_en_q    <= irq_en_d;
            irq_stat_q  <= irq_stat_d;
            pad_o_q     <= pad_o_d;
            pad_oe_q    <= pad_oe_d;
            sync1_q     <= pad_i;
            sync2_q     <= sync1_q;
            in_prev_q   <= in_val;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef IOBANK0_CTRL_DEBOUNCE_EN
    logic [NPADS-1:0] in_q, in_d;
    logic [7:0]       cnt_q [NPADS];
    logic [7:0]       cnt_d [NPADS];

    // IN flips only after the synchronised value has disagreed with it DEB_CYCLES times in a row.
    always_comb begin
        in_d = in_q;
        for (int i = 0; i < NPADS; i++) begin
            cnt_d[i] = 8'd0;
            if (sync2_q[i] != in_q[i]) begin
                if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
                    in_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
            for (int i = 0; i < NPADS; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            in_q  <= in_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_val = in_q;
`else
    logic [7:0] unused_deb_cycles;
    assign unused_deb_cycles = 8'(DEB_CYCLES);
    assign in_val            = sync2_q;
`endif

    assign alt_i     = in_val;
    assign pad_o     = pad_o_q;
    assign pad_oe    = pad_oe_q;
    assign irq       = |irq_stat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_iobank0_ctrl.sv
// Directed bench for iobank0_ctrl: register table plus hand sequences for pad timing,
// reset, interrupts, backpressure and (when compiled in) debounce.
`timescale 1ns/1ps
module tb_iobank0_ctrl;
  localparam int NPADS = 20;
  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_OE   = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_ALT  = 3'd3;
  localparam logic [2:0] A_EN   = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_SET  = 3'd6;
  localparam logic [2:0] A_CLR  = 3'd7;
`ifdef IOBANK0_CTRL_DEBOUNCE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [NPADS-1:0] alt_o = '0;
  logic [NPADS-1:0] alt_oe = '0;
  logic [NPADS-1:0] alt_i;
  logic [NPADS-1:0] pad_o;
  logic [NPADS-1:0] pad_oe;
  logic [NPADS-1:0] pad_i = '0;
  logic irq;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  iobank0_ctrl #(.NPADS(NPADS), .DEB_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .alt_o(alt_o), .alt_oe(alt_oe), .alt_i(alt_i),
    .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i), .irq(irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic bus_txn(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL bus_ready_timeout: req_ready stuck at 0 for %0d cycles", n);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid_after_accept", {31'd0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
  endtask

  task automatic bus_wr(input logic [2:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    bus_txn(1'b1, addr, wdata, rd);
    check("write_rdata_zero", rd, 32'd0);
  endtask

  task automatic bus_rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_txn(1'b0, addr, 32'd0, rd);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic seen;

    // reset block
    repeat (3) @(negedge clk);
    check("reset_pad_oe", pad_oe, 32'd0);
    check("reset_pad_o", pad_o, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // GPIO drive with register-to-pad timing
    bus_wr(A_OE, 32'h000F0);
    check("oe_not_yet_on_pad", pad_oe, 32'd0);
    @(negedge clk);
    check("oe_on_pad", pad_oe, 32'h000F0);
    bus_wr(A_OUT, 32'h00030);
    check("out_not_yet_on_pad", pad_o, 32'd0);
    @(negedge clk);
    check("out_on_pad", pad_o, 32'h00030);
    bus_wr(A_SET, 32'h00040);
    bus_wr(A_CLR, 32'h00010);
    bus_rd_chk("out_set_clr", A_OUT, 32'h00060);
    @(negedge clk);
    check("pad_o_after_set_clr", pad_o, 32'h00060);

    // reset in the middle of a read
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_OUT;
    @(negedge clk);
    req_valid = 1'b0;
    check("midread_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("midread_rdata", rsp_rdata, 32'h00060);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pad_oe", pad_oe, 32'd0);
    check("async_rst_pad_o", pad_o, 32'd0);
    check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("async_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    // register table
    add_vec(1'b0, A_OUT,  32'h0, 32'h0);
    add_vec(1'b0, A_OE,   32'h0, 32'h0);
    add_vec(1'b0, A_ALT,  32'h0, 32'h0);
    add_vec(1'b0, A_EN,   32'h0, 32'h0);
    add_vec(1'b0, A_STAT, 32'h0, 32'h0);
    add_vec(1'b0, A_IN,   32'h0, 32'h0);
    add_vec(1'b1, A_OUT,  32'hFFFF_FFFF, 32'h0);
    add_vec(1'b0, A_OUT,  32'h0, 32'h000F_FFFF);
    add_vec(1'b1, A_CLR,  32'h0000_0F0F, 32'h0);
    add_vec(1'b0, A_OUT,  32'h0, 32'h000F_F0F0);
    add_vec(1'b1, A_OUT,  32'h0, 32'h0);
    add_vec(1'b1, A_SET,  32'h0008_0001, 32'h0);
    add_vec(1'b0, A_OUT,  32'h0, 32'h0008_0001);
    add_vec(1'b0, A_SET,  32'h0, 32'h0);
    add_vec(1'b0, A_CLR,  32'h0, 32'h0);
    add_vec(1'b1, A_IN,   32'h0000_FFFF, 32'h0);
    add_vec(1'b0, A_IN,   32'h0, 32'h0);
    add_vec(1'b1, A_EN,   32'hABCD_E123, 32'h0);
    add_vec(1'b0, A_EN,   32'h0, 32'h000D_E123);
    add_vec(1'b1, A_EN,   32'h0, 32'h0);
    add_vec(1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0);
    add_vec(1'b0, A_STAT, 32'h0, 32'h0);
    add_vec(1'b1, A_OUT,  32'h0, 32'h0);
    add_vec(1'b0, A_OUT,  32'h0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      bus_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("table[%0d]", i), rd, exp_q.pop_front());
    end

    // alternate-function mux
    alt_o[19] = 1'b1; alt_oe[19] = 1'b1;
    bus_wr(A_ALT, 32'h80000);
    check("alt_not_yet_pad_o", pad_o, 32'd0);
    @(negedge clk);
    check("alt_pad_o", pad_o, 32'h80000);
    check("alt_pad_oe", pad_oe, 32'h80000);
    alt_o[19] = 1'b0;
    @(negedge clk);
    check("alt_o_follow", pad_o, 32'd0);
    alt_o[19] = 1'b1;
    @(negedge clk);
    bus_wr(A_ALT, 32'h0);
    check("alt_clear_pending", pad_oe, 32'h80000);
    @(negedge clk);
    check("alt_clear_pad_o", pad_o, 32'd0);
    check("alt_clear_pad_oe", pad_oe, 32'd0);
    alt_o = '0; alt_oe = '0;

    // interrupts
    bus_wr(A_EN, 32'h00004);
    @(negedge clk);
    pad_i[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("in_before_latency", alt_i, 32'd0);
    @(negedge clk);
    check("in_after_latency", alt_i, 32'h4);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_rd_chk("irq_stat_set", A_STAT, 32'h4);
    bus_rd_chk("in_read", A_IN, 32'h4);
    pad_i[2] = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("irq_held_after_fall", {31'd0, irq}, 32'd1);
    pad_i[2] = 1'b1;
    repeat (LAT) @(negedge clk);
    bus_wr(A_STAT, 32'h4);
    check("w1c_vs_set_irq", {31'd0, irq}, 32'd1);
    bus_rd_chk("w1c_vs_set_stat", A_STAT, 32'h4);
    bus_wr(A_EN, 32'h0);
    bus_rd_chk("en_clear_keeps_stat", A_STAT, 32'h4);
    bus_wr(A_STAT, 32'h4);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    bus_rd_chk("w1c_stat_zero", A_STAT, 32'h0);
    pad_i[2] = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    pad_i[2] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("disabled_edge_no_irq", {31'd0, irq}, 32'd0);
    pad_i = '0;

    // backpressure
    pad_i = 20'h00005;
    repeat (LAT + 3) @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_IN;
    @(negedge clk);
    req_we = 1'b1; req_addr = A_OUT; req_wdata = 32'h1;
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_rdata", rsp_rdata, 32'h5);
    pad_i = 20'h0000A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid[%0d]", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_hold_ready[%0d]", i), {31'd0, req_ready}, 32'd0);
      check($sformatf("bp_hold_rdata[%0d]", i), rsp_rdata, 32'h5);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed", {31'd0, rsp_valid}, 32'd0);
    check("bp_ready_back", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", {31'd0, rsp_valid}, 32'd1);
    check("bp_second_rdata", rsp_rdata, 32'd0);
    bus_rd_chk("bp_second_write", A_OUT, 32'h1);
    bus_wr(A_OUT, 32'h0);
    pad_i = '0;

`ifdef IOBANK0_CTRL_DEBOUNCE_EN
    // debounce
    repeat (LAT + 4) @(negedge clk);
    bus_wr(A_EN, 32'h1);
    @(negedge clk);
    pad_i[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | alt_i[0] | irq;
    end
    pad_i[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = seen | alt_i[0] | irq;
    end
    check("deb_glitch_filtered", {31'd0, seen}, 32'd0);
    pad_i[0] = 1'b1;
    repeat (17) @(negedge clk);
    check("deb_in_edge17", {31'd0, alt_i[0]}, 32'd0);
    @(negedge clk);
    check("deb_in_edge18", {31'd0, alt_i[0]}, 32'd1);
    @(negedge clk);
    check("deb_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    pad_i[0] = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
